// File: rtl/ex_stage_fwd_pkg.sv
// ex_pkg: shared ALU opcode and branch funct3 encodings for the execute stage.
package ex_pkg;
    localparam int XLEN_DEF = 32;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
    } alu_op_e;
    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;
endpackage

// File: rtl/ex_stage_fwd_alu.sv
// alu_xlen: combinational XLEN-bit ALU plus RV32I branch comparator.
module alu_xlen
    import ex_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [XLEN-1:0] cmp_a,
    input  logic [XLEN-1:0] cmp_b,
    input  logic [3:0]      op,
    input  logic [2:0]      br_fn,
    output logic [XLEN-1:0] result,
    output logic            taken
);
    localparam int SW = $clog2(XLEN);
    logic [SW-1:0] shamt;
    logic          lt, ltu, eq;
    assign shamt = b[SW-1:0];
    assign lt    = $signed(cmp_a) < $signed(cmp_b);
    assign ltu   = cmp_a < cmp_b;
    assign eq    = cmp_a == cmp_b;
    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:   result = a + b;
            ALU_SUB:   result = a - b;
            ALU_SLL:   result = a << shamt;
            ALU_SLT:   result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU:  result = {{(XLEN-1){1'b0}}, a < b};
            ALU_XOR:   result = a ^ b;
            ALU_SRL:   result = a >> shamt;
            ALU_SRA:   result = $signed(a) >>> shamt;
            ALU_OR:    result = a | b;
            ALU_AND:   result = a & b;
            ALU_PASSB: result = b;
            default:   result = '0;
        endcase
    end
    assign taken = (br_fn == BR_BEQ)  ? eq   :
                   (br_fn == BR_BNE)  ? !eq  :
                   (br_fn == BR_BLT)  ? lt   :
                   (br_fn == BR_BGE)  ? !lt  :
                   (br_fn == BR_BLTU) ? ltu  :
                   (br_fn == BR_BGEU) ? !ltu : 1'b0;
endmodule

// File: rtl/ex_stage_fwd.sv
// ex_stage_fwd: RV32I execute stage with EX/MEM and WB operand forwarding,
// valid/ready handshake, flush, link handling and a one-cycle fetch redirect.
module ex_stage_fwd
    import ex_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int RAW    = 5,
    parameter int FWD_EN = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic [XLEN-1:0] in_imm,
    input  logic [RAW-1:0]  in_rs1,
    input  logic [RAW-1:0]  in_rs2,
    input  logic [RAW-1:0]  in_rd,
    input  logic [3:0]      in_alu_op,
    input  logic [2:0]      in_br_fn,
    input  logic            in_b_imm_sel,
    input  logic            in_a_pc_sel,
    input  logic            in_branch,
    input  logic            in_jal,
    input  logic            in_jalr,
    input  logic            in_memwrite,
    input  logic            in_regwrite,
    input  logic            in_wb_sel,
    input  logic            wb_fwd_en,
    input  logic [RAW-1:0]  wb_fwd_rd,
    input  logic [XLEN-1:0] wb_fwd_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_alu,
    output logic [XLEN-1:0] out_wdata,
    output logic [RAW-1:0]  out_rd,
    output logic            out_memwrite,
    output logic            out_regwrite,
    output logic            out_wb_sel,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);
    localparam bit FEN = FWD_EN != 0;
    logic            fire, taken, ex_ok, redir;
    logic [XLEN-1:0] fwd_a, fwd_b, op_a, op_b, result, jt;
    assign in_ready = out_ready | ~out_valid;
    assign fire     = in_valid & in_ready & ~flush & ~redirect_valid;
    // Loads in EX/MEM are never self-forwarded; upstream stalls cover load-use.
    assign ex_ok = out_valid & out_regwrite & ~out_wb_sel;
    assign fwd_a = (FEN && in_rs1 != '0 && ex_ok && out_rd == in_rs1) ? out_alu :
                   (FEN && in_rs1 != '0 && wb_fwd_en && wb_fwd_rd == in_rs1) ? wb_fwd_data : in_a;
    assign fwd_b = (FEN && in_rs2 != '0 && ex_ok && out_rd == in_rs2) ? out_alu :
                   (FEN && in_rs2 != '0 && wb_fwd_en && wb_fwd_rd == in_rs2) ? wb_fwd_data : in_b;
    assign op_a  = in_a_pc_sel ? in_pc : fwd_a;
    assign op_b  = in_b_imm_sel ? in_imm : fwd_b;
    assign jt    = fwd_a + in_imm;
    assign redir = in_jal | in_jalr | (in_branch & taken);
    alu_xlen #(.XLEN(XLEN)) u_alu (
        .a(op_a), .b(op_b), .cmp_a(fwd_a), .cmp_b(fwd_b),
        .op(in_alu_op), .br_fn(in_br_fn), .result(result), .taken(taken)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            out_alu        <= '0;
            out_wdata      <= '0;
            out_rd         <= '0;
            out_memwrite   <= 1'b0;
            out_regwrite   <= 1'b0;
            out_wb_sel     <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else if (flush) begin
            out_valid      <= 1'b0;
            redirect_valid <= 1'b0;
        end else begin
            redirect_valid <= fire & redir;
            if (fire) begin
                out_valid    <= 1'b1;
                out_alu      <= (in_jal | in_jalr) ? in_pc + XLEN'(4) : result;
                out_wdata    <= fwd_b;
                out_rd       <= in_rd;
                out_memwrite <= in_memwrite;
                out_regwrite <= in_regwrite;
                out_wb_sel   <= in_wb_sel;
                redirect_pc  <= in_jalr ? {jt[XLEN-1:1], 1'b0} : in_pc + in_imm;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ex_stage_fwd.sv
// tb_ex_stage_fwd: table vectors, directed corner sequences and random stimulus
// checked against a transaction-level model of the execute stage.
module tb_ex_stage_fwd;
    import ex_pkg::*;
    typedef struct {
        logic [31:0] pc, a, b, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  op;
        logic [2:0]  fn;
        logic        bsel, asel, br, jal, jalr, mw, rw, ws;
    } instr_t;
    typedef struct {
        instr_t      i;
        logic [31:0] e_alu;
        logic        e_rv;
        logic [31:0] e_rpc;
    } vec_t;

    logic        clk = 0, rst_n = 0;
    logic        in_valid = 0, in_ready;
    logic [31:0] in_pc = 0, in_a = 0, in_b = 0, in_imm = 0;
    logic [4:0]  in_rs1 = 0, in_rs2 = 0, in_rd = 0;
    logic [3:0]  in_alu_op = 0;
    logic [2:0]  in_br_fn = 0;
    logic        in_b_imm_sel = 0, in_a_pc_sel = 0, in_branch = 0, in_jal = 0, in_jalr = 0;
    logic        in_memwrite = 0, in_regwrite = 0, in_wb_sel = 0;
    logic        wb_fwd_en = 0;
    logic [4:0]  wb_fwd_rd = 0;
    logic [31:0] wb_fwd_data = 0;
    logic        flush = 0, out_valid, out_ready = 1;
    logic [31:0] out_alu, out_wdata, redirect_pc;
    logic [4:0]  out_rd;
    logic        out_memwrite, out_regwrite, out_wb_sel, redirect_valid;

    int nvec = 0, nbad = 0;
    logic        m_valid = 0, m_rv = 0, m_mw = 0, m_rw = 0, m_ws = 0;
    logic [31:0] m_alu = 0, m_wdata = 0, m_rpc = 0;
    logic [4:0]  m_rd = 0;
    vec_t        tab[$];

    always #5 clk = ~clk;

    ex_stage_fwd dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_a(in_a), .in_b(in_b), .in_imm(in_imm),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_alu_op(in_alu_op),
        .in_br_fn(in_br_fn), .in_b_imm_sel(in_b_imm_sel), .in_a_pc_sel(in_a_pc_sel),
        .in_branch(in_branch), .in_jal(in_jal), .in_jalr(in_jalr),
        .in_memwrite(in_memwrite), .in_regwrite(in_regwrite), .in_wb_sel(in_wb_sel),
        .wb_fwd_en(wb_fwd_en), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_alu(out_alu), .out_wdata(out_wdata), .out_rd(out_rd),
        .out_memwrite(out_memwrite), .out_regwrite(out_regwrite), .out_wb_sel(out_wb_sel),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (op)
            0:  return a + b;
            1:  return a - b;
            2:  return a << sh;
            3:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4:  return (a < b) ? 32'd1 : 32'd0;
            5:  return a ^ b;
            6:  return a >> sh;
            7:  return $unsigned($signed(a) >>> sh);
            8:  return a | b;
            9:  return a & b;
            10: return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_taken(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (fn)
            3'b000: return a == b;
            3'b001: return a != b;
            3'b100: return sa < sb;
            3'b101: return sa >= sb;
            3'b110: return a < b;
            3'b111: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_fwd(input logic [4:0] rs, input logic [31:0] raw);
        if (rs == 0) return raw;
        if (m_valid && m_rw && !m_ws && m_rd == rs) return m_alu;
        if (wb_fwd_en && wb_fwd_rd == rs) return wb_fwd_data;
        return raw;
    endfunction

    // One clock: check in_ready, predict next state, cross the edge, compare.
    task automatic step();
        logic        f, tk, nv, nrv;
        logic [31:0] fa, fb, res, nalu, nrpc;
        #1;
        chk("in_ready", in_ready, out_ready | !m_valid);
        f   = in_valid && (out_ready || !m_valid) && !flush && !m_rv;
        fa  = ref_fwd(in_rs1, in_a);
        fb  = ref_fwd(in_rs2, in_b);
        res = ref_alu(in_alu_op, in_a_pc_sel ? in_pc : fa, in_b_imm_sel ? in_imm : fb);
        tk  = ref_taken(in_br_fn, fa, fb);
        nalu = (in_jal || in_jalr) ? in_pc + 4 : res;
        nrpc = in_jalr ? ((fa + in_imm) & ~32'd1) : in_pc + in_imm;
        nrv  = !flush && f && (in_jal || in_jalr || (in_branch && tk));
        nv   = flush ? 1'b0 : f ? 1'b1 : out_ready ? 1'b0 : m_valid;
        @(posedge clk);
        #1;
        if (f && !flush) begin
            m_alu = nalu; m_wdata = fb; m_rd = in_rd;
            m_mw = in_memwrite; m_rw = in_regwrite; m_ws = in_wb_sel; m_rpc = nrpc;
        end
        m_valid = nv;
        m_rv = nrv;
        chk("out_valid", out_valid, m_valid);
        chk("redirect_valid", redirect_valid, m_rv);
        if (m_rv) chk("redirect_pc", redirect_pc, m_rpc);
        if (m_valid) begin
            chk("out_alu", out_alu, m_alu);
            chk("out_wdata", out_wdata, m_wdata);
            chk("out_rd", out_rd, m_rd);
            chk("out_ctl", {out_memwrite, out_regwrite, out_wb_sel}, {m_mw, m_rw, m_ws});
        end
    endtask

    function automatic instr_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] imm, input logic bsel);
        instr_t t;
        t = '{pc: 32'h200, a: a, b: b, imm: imm, rs1: 0, rs2: 0, rd: 5, op: op, fn: 0,
              bsel: bsel, asel: 0, br: 0, jal: 0, jalr: 0, mw: 0, rw: 1, ws: 0};
        return t;
    endfunction

    task automatic issue(input instr_t t);
        in_valid = 1; in_pc = t.pc; in_a = t.a; in_b = t.b; in_imm = t.imm;
        in_rs1 = t.rs1; in_rs2 = t.rs2; in_rd = t.rd; in_alu_op = t.op; in_br_fn = t.fn;
        in_b_imm_sel = t.bsel; in_a_pc_sel = t.asel; in_branch = t.br; in_jal = t.jal;
        in_jalr = t.jalr; in_memwrite = t.mw; in_regwrite = t.rw; in_wb_sel = t.ws;
    endtask

    task automatic idle();
        in_valid = 0; flush = 0; wb_fwd_en = 0; out_ready = 1;
    endtask

    task automatic check_reset_outputs(input string n);
        chk({n, "_valid"}, out_valid, 0);
        chk({n, "_rv"}, redirect_valid, 0);
        chk({n, "_data"}, out_alu | out_wdata | redirect_pc, 0);
        chk({n, "_ctl"}, {out_rd, out_memwrite, out_regwrite, out_wb_sel}, 0);
    endtask

    initial begin
        instr_t t;
        vec_t   v;
        // ALU operations and control transfers from an empty stage
        tab.push_back('{mk(ALU_ADD, 5, 7, 0, 0), 32'd12, 1'b0, 32'd0});
        tab.push_back('{mk(ALU_SUB, 5, 7, 0, 0), 32'hFFFFFFFE, 1'b0, 32'd0});
        tab.push_back('{mk(ALU_SLL, 1, 33, 0, 0), 32'd2, 1'b0, 32'd0});
        tab.push_back('{mk(ALU_SLT, 32'hFFFFFFFF, 1, 0, 0), 32'd1, 1'b0, 32'd0});
        tab.push_back('{mk(ALU_SLTU, 32'hFFFFFFFF, 1, 0, 0), 32'd0, 1'b0, 32'd0});
        tab.push_back('{mk(ALU_XOR, 32'hF0F0, 32'hFF00, 0, 0), 32'h0FF0, 1'b0, 32'd0});
        tab.push_back('{mk(ALU_SRL, 32'h80000000, 4, 0, 0), 32'h08000000, 1'b0, 32'd0});
        tab.push_back('{mk(ALU_SRA, 32'h80000000, 4, 0, 0), 32'hF8000000, 1'b0, 32'd0});
        tab.push_back('{mk(ALU_OR, 32'hF0, 32'h0F, 0, 0), 32'hFF, 1'b0, 32'd0});
        tab.push_back('{mk(ALU_AND, 32'hF0, 32'h3C, 0, 0), 32'h30, 1'b0, 32'd0});
        tab.push_back('{mk(ALU_PASSB, 9, 9, 32'h1234, 1), 32'h1234, 1'b0, 32'd0});
        t = mk(ALU_ADD, 9, 9, 32'h2000, 1); t.asel = 1; t.pc = 32'h1000;
        tab.push_back('{t, 32'h3000, 1'b0, 32'd0});
        t = mk(ALU_ADD, 3, 3, 32'h20, 0); t.pc = 32'h100; t.br = 1; t.fn = BR_BEQ;
        tab.push_back('{t, 32'd6, 1'b1, 32'h120});
        t.fn = BR_BNE;
        tab.push_back('{t, 32'd6, 1'b0, 32'd0});
        t.fn = 3'b010;
        tab.push_back('{t, 32'd6, 1'b0, 32'd0});
        t = mk(ALU_ADD, 32'hFFFFFFFE, 1, 32'hFFFFFFF8, 0); t.pc = 32'h100; t.br = 1; t.fn = BR_BLT;
        tab.push_back('{t, 32'hFFFFFFFF, 1'b1, 32'hF8});
        t = mk(ALU_ADD, 1, 32'hFFFFFFFF, 4, 0); t.pc = 32'h100; t.br = 1; t.fn = BR_BGEU;
        tab.push_back('{t, 32'd0, 1'b0, 32'd0});
        t = mk(ALU_ADD, 32'hFFFFFFFF, 32'hFFFFFFFF, 4, 0); t.pc = 32'h100; t.br = 1; t.fn = BR_BGE;
        tab.push_back('{t, 32'hFFFFFFFE, 1'b1, 32'h104});
        t = mk(ALU_ADD, 1, 2, 8, 0); t.pc = 32'h100; t.br = 1; t.fn = BR_BLTU;
        tab.push_back('{t, 32'd3, 1'b1, 32'h108});
        t = mk(ALU_ADD, 32'h203, 0, 2, 1); t.pc = 32'h40; t.jalr = 1;
        tab.push_back('{t, 32'h44, 1'b1, 32'h204});
        t = mk(ALU_ADD, 0, 0, 32'h100, 1); t.pc = 32'h40; t.jal = 1;
        tab.push_back('{t, 32'h44, 1'b1, 32'h140});

        #2;
        check_reset_outputs("reset");
        chk("reset_in_ready", in_ready, 1);
        @(posedge clk); #1;
        rst_n = 1;

        foreach (tab[k]) begin
            v = tab[k];
            idle(); step();
            issue(v.i); step();
            chk("tab_alu", out_alu, v.e_alu);
            chk("tab_rv", redirect_valid, v.e_rv);
            if (v.e_rv) chk("tab_rpc", redirect_pc, v.e_rpc);
        end

        // back-to-back self-forward
        idle(); step();
        t = mk(ALU_ADD, 0, 0, 5, 1); t.rd = 1; issue(t); step();
        t = mk(ALU_ADD, 32'h99, 32'h99, 0, 0); t.rs1 = 1; t.rs2 = 1; t.rd = 2; issue(t);
        #1 chk("b2b_ready", in_ready, 1);
        step();
        chk("b2b_alu", out_alu, 10);
        chk("b2b_wdata", out_wdata, 5);

        // EX/MEM beats WB; x0 never forwards; WB alone forwards
        t = mk(ALU_ADD, 0, 0, 9, 1); t.rd = 3; issue(t); step();
        t = mk(ALU_ADD, 32'h55, 0, 0, 1); t.rs1 = 3; t.rd = 4; issue(t);
        wb_fwd_en = 1; wb_fwd_rd = 3; wb_fwd_data = 7; step();
        chk("prio_ex", out_alu, 9);
        wb_fwd_en = 0;
        t = mk(ALU_ADD, 0, 0, 9, 1); t.rd = 0; issue(t); step();
        t = mk(ALU_ADD, 32'h11, 0, 0, 1); t.rd = 4; issue(t);
        wb_fwd_en = 1; wb_fwd_rd = 0; wb_fwd_data = 7; step();
        chk("x0_raw", out_alu, 32'h11);
        idle(); step();
        t = mk(ALU_ADD, 32'h55, 0, 0, 1); t.rs1 = 3; issue(t);
        wb_fwd_en = 1; wb_fwd_rd = 3; wb_fwd_data = 7; step();
        chk("prio_wb", out_alu, 7);

        // taken branch squashes the following instruction
        idle(); step();
        t = mk(ALU_ADD, 3, 3, 32'h20, 0); t.pc = 32'h100; t.br = 1; issue(t); step();
        chk("beq_rv", redirect_valid, 1);
        chk("beq_rpc", redirect_pc, 32'h120);
        issue(mk(ALU_ADD, 1, 1, 0, 0)); step();
        chk("beq_squash_valid", out_valid, 0);
        chk("beq_pulse_end", redirect_valid, 0);

        // redirect pulse still lasts one cycle under stall
        idle(); issue(t); step();
        idle(); out_ready = 0; step();
        chk("stall_rv", redirect_valid, 0);
        chk("stall_hold", out_valid, 1);

        // backpressure: three stalled cycles then release
        idle(); step();
        issue(mk(ALU_ADD, 1, 2, 0, 0)); step();
        issue(mk(ALU_ADD, 10, 20, 0, 0)); out_ready = 0;
        for (int c = 0; c < 3; c++) begin
            #1 chk("bp_ready", in_ready, 0);
            step();
            chk("bp_alu", out_alu, 3);
            chk("bp_valid", out_valid, 1);
        end
        out_ready = 1; step();
        chk("bp_release", out_alu, 30);

        // flush overrides stall; flush suppresses a would-be redirect
        out_ready = 0; flush = 1; step();
        chk("flush_stall", out_valid, 0);
        t = mk(ALU_ADD, 0, 0, 8, 1); t.jal = 1; issue(t); out_ready = 1; flush = 1; step();
        chk("flush_jal_rv", redirect_valid, 0);
        chk("flush_jal_valid", out_valid, 0);

        // async reset mid-stream
        idle(); issue(t); step();
        #2 rst_n = 0;
        #1 check_reset_outputs("async");
        m_valid = 0; m_rv = 0;
        @(posedge clk); #1;
        rst_n = 1;
        idle(); step();

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            int kind;
            kind = $urandom % 8;
            t.pc = $urandom & 32'hFFFC; t.a = ($urandom % 2) ? $urandom : $urandom % 8;
            t.b = ($urandom % 2) ? $urandom : $urandom % 8; t.imm = $urandom;
            t.rs1 = 5'($urandom_range(0, 3)); t.rs2 = 5'($urandom_range(0, 3));
            t.rd = 5'($urandom_range(0, 3)); t.op = 4'($urandom_range(0, 11));
            t.fn = 3'($urandom); t.bsel = 1'($urandom); t.asel = ($urandom % 6) == 0;
            t.br = kind == 0; t.jal = kind == 1; t.jalr = kind == 2;
            t.mw = 1'($urandom); t.rw = 1'($urandom); t.ws = ($urandom % 4) == 0;
            issue(t);
            in_valid = ($urandom % 4) != 0;
            out_ready = ($urandom % 4) != 0;
            flush = ($urandom % 16) == 0;
            wb_fwd_en = 1'($urandom); wb_fwd_rd = 5'($urandom_range(0, 3)); wb_fwd_data = $urandom;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule

// File: doc/ex_stage_fwd.md
Name: ex_stage_fwd

Overview:
- Parametrised execute stage for the pipelined RV32I core; replaces the fixed 32-bit EX/MEM register stage.
- Adds operand forwarding (EX/MEM self-forward, plus external WB), a valid/ready handshake on both sides, flush, and JAL/JALR link handling.
- Sits between the ID/EX register and the memory stage.
- Issues a registered, one-cycle redirect toward fetch and squashes the wrong-path instruction that follows it.

Parameters:
- XLEN, 32, datapath width; ALU, operands and PC.
- RAW, 5, register address width.
- FWD_EN, 1, 1 = forwarding muxes present; 0 = raw operands used.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  ID/EX slot holds an instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_pc, in_a, in_b, in_imm  in  XLEN  PC, rs1 value, rs2 value, immediate.
- in_rs1, in_rs2, in_rd  in  RAW  source and destination register addresses.
- in_alu_op  in  4  ALU operation, encoded per alu_op_e.
- in_br_fn  in  3  branch compare, RV32I funct3 encoding.
- in_b_imm_sel  in  1  1 = use immediate as operand B.
- in_a_pc_sel  in  1  1 = use PC as operand A (AUIPC).
- in_branch, in_jal, in_jalr  in  1  control-transfer type.
- in_memwrite, in_regwrite, in_wb_sel  in  1  downstream controls; wb_sel 1 = load data.
- wb_fwd_en  in  1  WB stage is writing a register.
- wb_fwd_rd  in  RAW  WB destination register.
- wb_fwd_data  in  XLEN  WB write data.
- flush  in  1  kill the stage contents.
- out_valid  out  1  EX/MEM register holds an instruction.
- out_ready  in  1  memory stage accepts.
- out_alu, out_wdata  out  XLEN  ALU result (or link PC+4); store data.
- out_rd  out  RAW  destination register.
- out_memwrite, out_regwrite, out_wb_sel  out  1  registered controls.
- redirect_valid  out  1  one-cycle PC redirect.
- redirect_pc  out  XLEN  redirect target.

Behaviour:
- Reset (rst_n low, async): all outputs 0, including out_valid and redirect_valid.
- Handshake:
  - in_ready = out_ready | ~out_valid. It is combinational and has no dependency on in_valid.
  - Fire = in_valid & in_ready & ~flush & ~redirect_valid.
  - On fire, the output register loads and out_valid goes to 1 on the next edge; latency is 1 cycle.
  - If not fire and out_ready is high, out_valid goes to 0.
  - If out_ready is low, outputs hold and are stable.
- Forwarding (FWD_EN=1), evaluated per source:
  - Address 0 never forwards.
  - First priority: EX/MEM self-forward when out_valid & out_regwrite & ~out_wb_sel & out_rd==rs; uses out_alu.
  - Second priority: WB forward when wb_fwd_en & wb_fwd_rd==rs; uses wb_fwd_data.
  - Otherwise the raw operand is used.
  - The forwarded rs2 value drives both ALU operand B (when b_imm_sel=0) and out_wdata.
  - Load-use hazards are excluded: the hazard unit upstream stalls for them.
- ALU:
  - XLEN-bit, wrap-around arithmetic.
  - Shift amount is the low log2(XLEN) bits of operand B.
  - SLT is signed; SLTU is unsigned.
  - Operand A is in_pc when a_pc_sel=1.
- Branch compare: uses the forwarded operands, per br_fn (BEQ, BNE, BLT, BGE, BLTU, BGEU); any other code means not taken.
- Link: if jal or jalr, out_alu = in_pc + 4.
- Redirect: on fire with jal, or branch & taken, or jalr:
  - redirect_valid = 1 on the next cycle, for exactly one cycle.
  - redirect_pc = in_pc + in_imm; for jalr it is (fwd_a + in_imm) with bit 0 cleared.
  - While redirect_valid=1, an in_valid instruction is consumed and discarded (in_ready stays per the formula, no out_valid).
- Flush:
  - Next edge: out_valid=0 and redirect_valid=0, and the input is discarded.
  - Flush overrides out_ready=0.
- Simultaneous events:
  - Flush together with a fire that would redirect: no redirect is generated.
  - Stall (out_ready=0) together with redirect_valid: the pulse still lasts one cycle.
- Reset mid-operation: reset dominates; the pipeline is empty after release.

Decomposition:
- Package ex_pkg: alu_op_e (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASSB), branch funct3 constants, XLEN default.
- Sub-module alu_xlen, parametrised on XLEN. It is combinational: result plus branch_taken. The stage instantiates it once.

Test Plan:
- Back-to-back dependency: ADDI x1=5, then ADD x2=x1+x1 -> out_alu=10 via self-forward, with no stall.
- WB vs EX/MEM priority: wb_fwd x3=7 while EX/MEM holds x3=9 -> consumer sees 9; with rd=0 forwarding, raw value is used.
- BEQ taken: in_pc=0x100, imm=0x20, a==b -> redirect_valid 1 cycle with redirect_pc=0x120; the next in_valid is discarded (no out_valid).
- JALR: a=0x203, imm=2, pc=0x40 -> redirect_pc=0x204 and out_alu=0x44.
- Backpressure: out_ready=0 for 3 cycles -> outputs stable and in_ready=0; on release the queued instruction appears 1 cycle later.
- Flush with out_ready=0, and async reset asserted mid-stream -> out_valid=0 next edge (flush) or immediately (reset); all outputs are 0 after reset.
